// File: rtl/chan_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : chan_sel_seq
// Purpose  : Registered N-channel selector with valid/ready output, direct and
//            scan modes. Optional CHAN_SEL_SNAPSHOT_EN freezes in_data at start.
// Revision : 1.0 - initial release
// ============================================================================
module chan_sel_seq #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_err,
  output logic                     busy,
  output logic                     done
);

  localparam int c_LAST_CH = N_CH - 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_mode;
  logic [SEL_W-1:0]         r_idx;
  logic [DATA_W-1:0]        r_data;
  logic                     r_err;
  logic                     r_done;

  logic                     w_load;
  logic                     w_done_nxt;
  logic                     w_last;
  logic [SEL_W-1:0]         w_load_idx;
  logic [DATA_W-1:0]        w_load_data;
  logic                     w_load_err;
  logic [N_CH*DATA_W-1:0]   w_src;

`ifdef CHAN_SEL_SNAPSHOT_EN
  logic [N_CH*DATA_W-1:0]   r_snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_snap <= in_data;
    end
  end

  // The first item is loaded on the same edge as the snapshot, so it reads in_data directly.
  assign w_src = (r_state == S_IDLE) ? in_data : r_snap;
`else
  assign w_src = in_data;
`endif

  assign w_last = (int'(r_idx) == c_LAST_CH);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_EMIT;
          w_load      = 1'b1;
          w_load_idx  = mode ? '0 : sel;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (!r_mode || w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_load_idx = r_idx + SEL_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Indices at or above N_CH (non power-of-2 N_CH) yield zero data and flag an error.
  always_comb begin
    w_load_data = '0;
    w_load_err  = (int'(w_load_idx) >= N_CH);
    for (int k = 0; k < N_CH; k++) begin
      if (int'(w_load_idx) == k) begin
        w_load_data = w_src[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
      end
      if (w_load) begin
        r_idx  <= w_load_idx;
        r_data <= w_load_data;
        r_err  <= w_load_err;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_idx;
  assign out_err   = r_err;
  assign out_valid = (r_state == S_EMIT);
  assign busy      = (r_state == S_EMIT);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chan_sel_seq.sv
`default_nettype none
// Bench for chan_sel_seq: directed literal checks, then randomized traffic
// compared every cycle against an item-queue model of the selector.
module tb_chan_sel_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic [3:0]   sel;
  logic         mode, start, out_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_ch;
  logic         out_valid, out_err, busy, done;

  logic [95:0]  in12;
  logic [3:0]   sel12;
  logic         mode12, start12, ready12;
  logic [7:0]   o12_data;
  logic [3:0]   o12_ch;
  logic         o12_valid, o12_err, o12_busy, o12_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_sel_seq #(.N_CH(16), .DATA_W(8)) dut16 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .mode(mode),
    .start(start), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .out_err(out_err), .busy(busy), .done(done)
  );

  chan_sel_seq #(.N_CH(12), .DATA_W(8)) dut12 (
    .clk(clk), .reset(reset), .in_data(in12), .sel(sel12), .mode(mode12),
    .start(start12), .out_data(o12_data), .out_ch(o12_ch), .out_valid(o12_valid),
    .out_ready(ready12), .out_err(o12_err), .busy(o12_busy), .done(o12_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] chan(input logic [127:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  // Model: the item on display plus a queue of channels still to be emitted.
  logic         m_on = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_done = 1'b0;
  int           m_ch = 0;
  logic [7:0]   m_data = '0;
  logic [127:0] m_snap = '0;
  int           m_q[$];

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      check("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("m_busy", {31'd0, busy}, {31'd0, m_valid});
      check("m_done", {31'd0, done}, {31'd0, m_done});
      if (m_valid) begin
        check("m_data", {24'd0, out_data}, {24'd0, m_data});
        check("m_ch", {28'd0, out_ch}, m_ch);
        check("m_err", {31'd0, out_err}, 32'd0);
      end
    end
    if (reset) begin
      m_on    = 1'b1;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_q.delete();
    end else if (m_on) begin
      m_done = 1'b0;
      if (m_valid) begin
        if (out_ready) begin
          if (m_q.size() == 0) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
          end else begin
            m_ch = m_q.pop_front();
`ifdef CHAN_SEL_SNAPSHOT_EN
            m_data = chan(m_snap, m_ch);
`else
            m_data = chan(in_data, m_ch);
`endif
          end
        end
      end else if (start) begin
        m_valid = 1'b1;
        m_snap  = in_data;
        if (mode) begin
          m_ch = 0;
          for (int k = 1; k < 16; k++) m_q.push_back(k);
        end else begin
          m_ch = int'(sel);
        end
        m_data = chan(in_data, m_ch);
      end
    end
  end

  task automatic ramp();
    for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
  endtask

  initial begin
    logic [7:0] snap_exp;
`ifdef CHAN_SEL_SNAPSHOT_EN
    snap_exp = 8'h19;
`else
    snap_exp = 8'hAA;
`endif
    reset = 1'b1; start = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b0; in_data = '0;
    start12 = 1'b0; mode12 = 1'b0; sel12 = '0; ready12 = 1'b0;
    for (int k = 0; k < 12; k++) in12[k*8 +: 8] = 8'h20 + 8'(k);
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_ch", {28'd0, out_ch}, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    reset = 1'b0;
    ramp();

    // direct select of channel 5
    mode = 1'b0; sel = 4'd5; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    check("dir_valid", {31'd0, out_valid}, 32'd1);
    check("dir_data", {24'd0, out_data}, 32'h15);
    check("dir_ch", {28'd0, out_ch}, 32'd5);
    tick();
    check("dir_done", {31'd0, done}, 32'd1);
    check("dir_busy", {31'd0, busy}, 32'd0);
    tick();
    check("dir_done_w", {31'd0, done}, 32'd0);

    // back-to-back scan
    mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("scan_data", {24'd0, out_data}, 32'h10 + i);
      check("scan_ch", {28'd0, out_ch}, i);
      check("scan_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    check("scan_done", {31'd0, done}, 32'd1);
    check("scan_busy", {31'd0, busy}, 32'd0);
    tick();
    check("scan_done_w", {31'd0, done}, 32'd0);

    // backpressure on item 7, with a start pulse that must be ignored
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (7) tick();
    out_ready = 1'b0; start = 1'b1; mode = 1'b0; sel = 4'd2;
    repeat (3) begin
      tick();
      check("bp_data", {24'd0, out_data}, 32'h17);
      check("bp_ch", {28'd0, out_ch}, 32'd7);
    end
    start = 1'b0; mode = 1'b1; out_ready = 1'b1;
    tick();
    check("bp_next", {24'd0, out_data}, 32'h18);
    repeat (7) tick();
    tick();
    check("bp_done", {31'd0, done}, 32'd1);
    tick();
    check("bp_ignored", {31'd0, out_valid}, 32'd0);

    // reset in the middle of a scan
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("mid_ch4", {28'd0, out_ch}, 32'd4);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", {24'd0, out_data}, 32'd0);
    check("mr_ch", {28'd0, out_ch}, 32'd0);
    tick();
    check("mr_nodone", {31'd0, done}, 32'd0);
    mode = 1'b0; sel = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    check("mr_new_data", {24'd0, out_data}, 32'h13);
    tick();
    check("mr_new_done", {31'd0, done}, 32'd1);

    // coherency of a scan when channel 9 changes after start
    mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    in_data[9*8 +: 8] = 8'hAA;
    repeat (9) tick();
    check("snap_ch", {28'd0, out_ch}, 32'd9);
    check("snap_data", {24'd0, out_data}, {24'd0, snap_exp});
    repeat (7) tick();
    check("snap_done", {31'd0, done}, 32'd1);
    ramp();

    // out-of-range index on a 12-channel instance
    mode12 = 1'b0; sel12 = 4'd13; start12 = 1'b1; ready12 = 1'b0;
    tick(); start12 = 1'b0;
    check("oor_valid", {31'd0, o12_valid}, 32'd1);
    check("oor_data", {24'd0, o12_data}, 32'd0);
    check("oor_ch", {28'd0, o12_ch}, 32'd13);
    check("oor_err", {31'd0, o12_err}, 32'd1);
    tick();
    check("oor_hold", {31'd0, o12_err}, 32'd1);
    ready12 = 1'b1;
    tick();
    check("oor_done", {31'd0, o12_done}, 32'd1);
    sel12 = 4'd11; start12 = 1'b1;
    tick(); start12 = 1'b0;
    check("c12_data", {24'd0, o12_data}, 32'h2B);
    check("c12_err", {31'd0, o12_err}, 32'd0);
    tick();
    check("c12_done", {31'd0, o12_done}, 32'd1);

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 4; w++) in_data[w*32 +: 32] = $urandom;
      start     = ($urandom % 3) == 0;
      mode      = $urandom % 2;
      sel       = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 300) == 0;
      tick();
    end
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
